// File: rtl/sha_message_block_loader.sv
// SHA-256 message block loader: packs a word stream into 512-bit blocks in
// expander history order (block_o[15] = oldest word), adding padding and length.
module sha_message_block_loader #(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        word_i,
  input  logic               word_valid_i,
  input  logic               word_last_i,
  output logic               word_ready_o,
  output logic [15:0][31:0]  block_o,
  output logic               block_valid_o,
  output logic               block_first_o,
  output logic               block_last_o,
  input  logic               block_ready_i
);

  typedef enum logic [1:0] {LOAD, PAD, LEN, OUT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          slot_q, slot_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0][31:0]   block_q, block_d;
  logic                valid_q, valid_d;
  logic                firstOut_q, firstOut_d;
  logic                lastOut_q, lastOut_d;
  logic                firstPend_q, firstPend_d;
  logic                nextPad_q, nextPad_d;
  logic                markerDone_q, markerDone_d;

  logic                wrEn;
  logic [31:0]         wrData;
  logic [63:0]         bitLen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      slot_q       <= '0;
      cnt_q        <= '0;
      block_q      <= '0;
      valid_q      <= 1'b0;
      firstOut_q   <= 1'b0;
      lastOut_q    <= 1'b0;
      firstPend_q  <= 1'b1;
      nextPad_q    <= 1'b0;
      markerDone_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      cnt_q        <= cnt_d;
      block_q      <= block_d;
      valid_q      <= valid_d;
      firstOut_q   <= firstOut_d;
      lastOut_q    <= lastOut_d;
      firstPend_q  <= firstPend_d;
      nextPad_q    <= nextPad_d;
      markerDone_q <= markerDone_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    cnt_d        = cnt_q;
    block_d      = block_q;
    valid_d      = valid_q;
    firstOut_d   = firstOut_q;
    lastOut_d    = lastOut_q;
    firstPend_d  = firstPend_q;
    nextPad_d    = nextPad_q;
    markerDone_d = markerDone_q;
    wrEn         = 1'b0;
    wrData       = 32'h0;
    bitLen       = 64'(cnt_q) << 5;

    unique case (state_q)
      LOAD: begin
        if (word_valid_i) begin
          wrEn   = 1'b1;
          wrData = word_i;
          cnt_d  = cnt_q + CNT_W'(1);
          if (slot_q == 4'd15) begin
            // A last word in slot 15 leaves no room: padding starts the next block
            state_d    = OUT;
            valid_d    = 1'b1;
            firstOut_d = firstPend_q;
            lastOut_d  = 1'b0;
            nextPad_d  = word_last_i;
          end else begin
            slot_d = slot_q + 4'd1;
            if (word_last_i) state_d = PAD;
          end
        end
      end
      PAD: begin
        wrEn         = 1'b1;
        wrData       = markerDone_q ? 32'h0 : 32'h8000_0000;
        markerDone_d = 1'b1;
        if (slot_q == 4'd13) begin
          state_d = LEN;
          slot_d  = 4'd14;
        end else if (slot_q == 4'd15) begin
          // Marker landed in slot 14/15: length goes into an extra all-pad block
          state_d    = OUT;
          valid_d    = 1'b1;
          firstOut_d = firstPend_q;
          lastOut_d  = 1'b0;
          nextPad_d  = 1'b1;
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end
      LEN: begin
        wrEn = 1'b1;
        if (slot_q == 4'd14) begin
          wrData = bitLen[63:32];
          slot_d = 4'd15;
        end else begin
          wrData     = bitLen[31:0];
          state_d    = OUT;
          valid_d    = 1'b1;
          firstOut_d = firstPend_q;
          lastOut_d  = 1'b1;
        end
      end
      OUT: begin
        if (block_ready_i) begin
          valid_d     = 1'b0;
          firstOut_d  = 1'b0;
          lastOut_d   = 1'b0;
          slot_d      = 4'd0;
          firstPend_d = 1'b0;
          if (lastOut_q) begin
            cnt_d        = '0;
            firstPend_d  = 1'b1;
            markerDone_d = 1'b0;
            state_d      = LOAD;
          end else begin
            state_d = nextPad_q ? PAD : LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    if (wrEn) block_d[4'd15 - slot_q] = wrData;
  end

  // Gated by rst_n so every output reads 0 while reset is held
  assign word_ready_o  = rst_n && (state_q == LOAD);
  assign block_o       = block_q;
  assign block_valid_o = valid_q;
  assign block_first_o = firstOut_q;
  assign block_last_o  = lastOut_q;

endmodule

// File: tb/tb_sha_message_block_loader.sv
// Scoreboard bench for sha_message_block_loader: directed messages push
// hand-computed blocks; a monitor pops and compares at each block handshake.
module tb_sha_message_block_loader;

  logic              clk;
  logic              rst_n;
  logic [31:0]       word_i;
  logic              word_valid_i;
  logic              word_last_i;
  logic              word_ready_o;
  logic [15:0][31:0] block_o;
  logic              block_valid_o;
  logic              block_first_o;
  logic              block_last_o;
  logic              block_ready_i;

  typedef struct {
    logic [15:0][31:0] blk;
    logic              first;
    logic              last;
  } exp_t;

  exp_t              expQ[$];
  logic [15:0][31:0] expBlk;
  int                total;
  int                bad;

  sha_message_block_loader #(.CNT_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .word_i(word_i),
    .word_valid_i(word_valid_i),
    .word_last_i(word_last_i),
    .word_ready_o(word_ready_o),
    .block_o(block_o),
    .block_valid_o(block_valid_o),
    .block_first_o(block_first_o),
    .block_last_o(block_last_o),
    .block_ready_i(block_ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: a handshake completes at the next posedge whenever valid && ready here
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && block_valid_o && block_ready_i) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_block: got %h want none", block_o);
        end else begin
          e = expQ.pop_front();
          checkOutput("block", block_o, e.blk);
          checkOutput("first", 512'(block_first_o), 512'(e.first));
          checkOutput("last", 512'(block_last_o), 512'(e.last));
        end
      end
    end
  end

  task automatic clearExp();
    expBlk = '0;
  endtask

  task automatic setM(input int k, input logic [31:0] v);
    expBlk[15-k] = v;
  endtask

  task automatic pushExp(input logic first, input logic last);
    exp_t e;
    e.blk   = expBlk;
    e.first = first;
    e.last  = last;
    expQ.push_back(e);
  endtask

  function automatic logic [31:0] dataWord(input int k);
    return 32'hA500_0000 + 32'(k);
  endfunction

  task automatic applyStimulus(input logic [31:0] data, input logic last);
    int waitCnt;
    @(negedge clk);
    word_i       = data;
    word_last_i  = last;
    word_valid_i = 1'b1;
    waitCnt      = 0;
    while (!word_ready_o && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!word_ready_o) begin
      total++;
      bad++;
      $display("[TB] FAIL word_accept_timeout: got ready=0 want ready=1");
    end else begin
      @(posedge clk);
    end
    #1;
    word_valid_i = 1'b0;
    word_last_i  = 1'b0;
  endtask

  task automatic sendMessage(input int n);
    for (int k = 0; k < n; k++) applyStimulus(dataWord(k), k == n - 1);
  endtask

  task automatic waitDrain();
    int waitCnt;
    waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 300) begin
      @(negedge clk);
      waitCnt++;
    end
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending want 0", expQ.size());
      expQ.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [15:0][31:0] held;
    logic              heldFirst;
    logic              heldLast;
    int                waitCnt;

    total         = 0;
    bad           = 0;
    word_i        = '0;
    word_valid_i  = 1'b0;
    word_last_i   = 1'b0;
    block_ready_i = 1'b1;
    rst_n         = 1'b0;
    #1;
    checkOutput("reset_ready", 512'(word_ready_o), 512'(0));
    checkOutput("reset_valid", 512'(block_valid_o), 512'(0));
    checkOutput("reset_block", block_o, 512'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", 512'(word_ready_o), 512'(1));

    // 1-word "abcd" message
    clearExp();
    setM(0, 32'h6162_6364); setM(1, 32'h8000_0000); setM(15, 32'h0000_0020);
    pushExp(1'b1, 1'b1);
    applyStimulus(32'h6162_6364, 1'b1);
    waitDrain();

    // 13 words: marker in slot 13, length 0x1A0
    clearExp();
    for (int k = 0; k < 13; k++) setM(k, dataWord(k));
    setM(13, 32'h8000_0000); setM(15, 32'h0000_01A0);
    pushExp(1'b1, 1'b1);
    sendMessage(13);
    waitDrain();

    // 14 words: marker in slot 14 forces a second, all-pad block
    clearExp();
    for (int k = 0; k < 14; k++) setM(k, dataWord(k));
    setM(14, 32'h8000_0000);
    pushExp(1'b1, 1'b0);
    clearExp();
    setM(15, 32'h0000_01C0);
    pushExp(1'b0, 1'b1);
    sendMessage(14);
    waitDrain();

    // 20 words: full data block then 4 data words + pad, length 0x280
    clearExp();
    for (int k = 0; k < 16; k++) setM(k, dataWord(k));
    pushExp(1'b1, 1'b0);
    clearExp();
    for (int k = 0; k < 4; k++) setM(k, dataWord(16 + k));
    setM(4, 32'h8000_0000); setM(15, 32'h0000_0280);
    pushExp(1'b0, 1'b1);
    sendMessage(20);
    waitDrain();

    // Back-pressure: 17 words with the consumer stalled after the first block
    clearExp();
    for (int k = 0; k < 16; k++) setM(k, dataWord(k));
    pushExp(1'b1, 1'b0);
    clearExp();
    setM(0, dataWord(16)); setM(1, 32'h8000_0000); setM(15, 32'h0000_0220);
    pushExp(1'b0, 1'b1);
    @(posedge clk);
    #1 block_ready_i = 1'b0;
    for (int k = 0; k < 16; k++) applyStimulus(dataWord(k), 1'b0);
    fork
      applyStimulus(dataWord(16), 1'b1);
      begin
        waitCnt = 0;
        while (!block_valid_o && waitCnt < 50) begin
          @(negedge clk);
          waitCnt++;
        end
        checkOutput("stall_valid_rise", 512'(block_valid_o), 512'(1));
        held      = block_o;
        heldFirst = block_first_o;
        heldLast  = block_last_o;
        checkOutput("stall_first", 512'(heldFirst), 512'(1));
        checkOutput("stall_last", 512'(heldLast), 512'(0));
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checkOutput("stall_block_stable", block_o, held);
          checkOutput("stall_valid_held", 512'(block_valid_o), 512'(1));
          checkOutput("stall_flags_stable", 512'({block_first_o, block_last_o}), 512'({heldFirst, heldLast}));
          checkOutput("stall_ready_low", 512'(word_ready_o), 512'(0));
        end
        @(posedge clk);
        #1 block_ready_i = 1'b1;
      end
    join
    waitDrain();

    // Reset mid-message after 7 words, then a clean 1-word message
    for (int k = 0; k < 7; k++) applyStimulus(dataWord(k), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_ready", 512'(word_ready_o), 512'(0));
    checkOutput("midreset_valid", 512'(block_valid_o), 512'(0));
    checkOutput("midreset_flags", 512'({block_first_o, block_last_o}), 512'(0));
    checkOutput("midreset_block", block_o, 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    clearExp();
    setM(0, 32'h6162_6364); setM(1, 32'h8000_0000); setM(15, 32'h0000_0020);
    pushExp(1'b1, 1'b1);
    applyStimulus(32'h6162_6364, 1'b1);
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
